jtag_tap_sampled: RTL and testbench

- JTAG TAP responder for the pad side of the SoC. It is the slave end of the tms/tck/tdi/tdo link that the bench-side JTAG VPI master drives.
- tck is treated as data: all pad inputs are oversampled in the wb_clk_i domain, so the block has a single clock domain.
- Implements the 16-state IEEE 1149.1 TAP FSM, the instruction register, IDCODE and BYPASS.
- Exposes the selected debug data register to the debug interface as one-cycle capture/shift/update strobes.

---
 rtl/jtag_tap_sampled_if.sv | 44 ++++
 rtl/jtag_tap_sampled.sv | 211 +++++++++++++++++++++
 tb/tb_jtag_tap_sampled.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_sampled_if.sv
// Pad-side JTAG link plus debug-DR strobe bundle for jtag_tap_sampled.
// trst_pad_i exists only when JTAG_TAP_TRST_EN is defined.
interface jtag_tap_sampled_if #(
  parameter int IR_WIDTH = 4
);
  logic                tck_pad_i;
  logic                tms_pad_i;
  logic                tdi_pad_i;
  logic                tdo_pad_o;
`ifdef JTAG_TAP_TRST_EN
  logic                trst_pad_i;
`endif
  logic [IR_WIDTH-1:0] ir_o;
  logic                debug_select_o;
  logic                capture_dr_o;
  logic                shift_dr_o;
  logic                update_dr_o;
  logic                tdi_o;
  logic                debug_tdo_i;

`ifdef JTAG_TAP_TRST_EN
  modport slave (
    input  tck_pad_i, tms_pad_i, tdi_pad_i, trst_pad_i, debug_tdo_i,
    output tdo_pad_o, ir_o, debug_select_o, capture_dr_o, shift_dr_o,
           update_dr_o, tdi_o
  );
  modport master (
    output tck_pad_i, tms_pad_i, tdi_pad_i, trst_pad_i, debug_tdo_i,
    input  tdo_pad_o, ir_o, debug_select_o, capture_dr_o, shift_dr_o,
           update_dr_o, tdi_o
  );
`else
  modport slave (
    input  tck_pad_i, tms_pad_i, tdi_pad_i, debug_tdo_i,
    output tdo_pad_o, ir_o, debug_select_o, capture_dr_o, shift_dr_o,
           update_dr_o, tdi_o
  );
  modport master (
    output tck_pad_i, tms_pad_i, tdi_pad_i, debug_tdo_i,
    input  tdo_pad_o, ir_o, debug_select_o, capture_dr_o, shift_dr_o,
           update_dr_o, tdi_o
  );
`endif
endinterface

// File: rtl/jtag_tap_sampled.sv
// IEEE 1149.1 TAP with tck oversampled in the wb_clk_i domain (IDCODE, BYPASS, external debug DR).
// Optional JTAG_TAP_TRST_EN adds a synchronised active-low trst_pad_i.
module jtag_tap_sampled #(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h14951185,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = 4'h2,
  parameter logic [IR_WIDTH-1:0] DEBUG_INSTR  = 4'h8,
  parameter int                  SYNC_STAGES  = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  jtag_tap_sampled_if.slave jtag
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    TLR   = 4'd0,  RTI   = 4'd1,  SELDR = 4'd2,  CAPDR = 4'd3,
    SHDR  = 4'd4,  EX1DR = 4'd5,  PAUDR = 4'd6,  EX2DR = 4'd7,
    UPDDR = 4'd8,  SELIR = 4'd9,  CAPIR = 4'd10, SHIR  = 4'd11,
    EX1IR = 4'd12, PAUIR = 4'd13, EX2IR = 4'd14, UPDIR = 4'd15
  } tap_state_e;

  tap_state_e state_r;
  tap_state_e next_state_s;

  logic [SYNC_STAGES-1:0] tck_sync_r;
  logic [SYNC_STAGES-1:0] tms_sync_r;
  logic [SYNC_STAGES-1:0] tdi_sync_r;
  logic                   tck_prev_r;
  logic                   tck_s, tms_s, tdi_s;
  logic                   rise_s, fall_s;
  logic                   rst_s;

  logic [IR_WIDTH-1:0]    ir_shift_r;
  logic [IR_WIDTH-1:0]    ir_r;
  logic                   dsel_r;
  logic [31:0]            dr_r;
  logic                   bypass_r;
  logic                   sel_idcode_s;
  logic                   sel_bypass_s;
  logic                   capture_r, shift_r, update_r, tdi_o_r, tdo_r;

`ifdef JTAG_TAP_TRST_EN
  logic [SYNC_STAGES-1:0] trst_sync_r;

  // trst synchroniser; a low synced value acts as a soft reset that leaves tck sampling alone
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      trst_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      trst_sync_r <= {trst_sync_r[SYNC_STAGES-2:0], jtag.trst_pad_i};
    end
  end

  assign rst_s = wb_rst_i | ~trst_sync_r[SYNC_STAGES-1];
`else
  assign rst_s = wb_rst_i;
`endif

  // tck synchroniser and edge history
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tck_sync_r <= {SYNC_STAGES{1'b0}};
      tck_prev_r <= 1'b0;
    end else begin
      tck_sync_r <= {tck_sync_r[SYNC_STAGES-2:0], jtag.tck_pad_i};
      tck_prev_r <= tck_s;
    end
  end

  // tms/tdi synchronisers, same depth as tck so they line up with the detected edge
  always_ff @(posedge wb_clk_i) begin
    if (rst_s) begin
      tms_sync_r <= {SYNC_STAGES{1'b0}};
      tdi_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      tms_sync_r <= {tms_sync_r[SYNC_STAGES-2:0], jtag.tms_pad_i};
      tdi_sync_r <= {tdi_sync_r[SYNC_STAGES-2:0], jtag.tdi_pad_i};
    end
  end

  assign tck_s  = tck_sync_r[SYNC_STAGES-1];
  assign tms_s  = tms_sync_r[SYNC_STAGES-1];
  assign tdi_s  = tdi_sync_r[SYNC_STAGES-1];
  assign rise_s = tck_s & ~tck_prev_r;
  assign fall_s = ~tck_s & tck_prev_r;

  assign sel_idcode_s = (ir_r == IDCODE_INSTR);
  assign sel_bypass_s = ~sel_idcode_s & ~dsel_r;

  // TAP state register, advanced once per detected tck rise
  always_ff @(posedge wb_clk_i) begin
    if (rst_s) begin
      state_r <= TLR;
    end else if (rise_s) begin
      state_r <= next_state_s;
    end else begin
      state_r <= state_r;
    end
  end

  // 1149.1 next-state function
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      TLR:     next_state_s = tms_s ? TLR   : RTI;
      RTI:     next_state_s = tms_s ? SELDR : RTI;
      SELDR:   next_state_s = tms_s ? SELIR : CAPDR;
      CAPDR:   next_state_s = tms_s ? EX1DR : SHDR;
      SHDR:    next_state_s = tms_s ? EX1DR : SHDR;
      EX1DR:   next_state_s = tms_s ? UPDDR : PAUDR;
      PAUDR:   next_state_s = tms_s ? EX2DR : PAUDR;
      EX2DR:   next_state_s = tms_s ? UPDDR : SHDR;
      UPDDR:   next_state_s = tms_s ? SELDR : RTI;
      SELIR:   next_state_s = tms_s ? TLR   : CAPIR;
      CAPIR:   next_state_s = tms_s ? EX1IR : SHIR;
      SHIR:    next_state_s = tms_s ? EX1IR : SHIR;
      EX1IR:   next_state_s = tms_s ? UPDIR : PAUIR;
      PAUIR:   next_state_s = tms_s ? EX2IR : PAUIR;
      EX2IR:   next_state_s = tms_s ? UPDIR : SHIR;
      UPDIR:   next_state_s = tms_s ? SELDR : RTI;
      default: next_state_s = TLR;
    endcase
  end

  // Instruction shift register and the latched instruction
  always_ff @(posedge wb_clk_i) begin
    if (rst_s) begin
      ir_shift_r <= {IR_WIDTH{1'b0}};
      ir_r       <= IDCODE_INSTR;
      dsel_r     <= 1'b0;
    end else if (rise_s) begin
      case (state_r)
        CAPIR:   ir_shift_r <= IR_CAPTURE;
        SHIR:    ir_shift_r <= {tdi_s, ir_shift_r[IR_WIDTH-1:1]};
        default: ir_shift_r <= ir_shift_r;
      endcase
      if (next_state_s == UPDIR) begin
        ir_r   <= ir_shift_r;
        dsel_r <= (ir_shift_r == DEBUG_INSTR);
      end else if (next_state_s == TLR) begin
        ir_r   <= IDCODE_INSTR;
        dsel_r <= 1'b0;
      end else begin
        ir_r   <= ir_r;
        dsel_r <= dsel_r;
      end
    end else begin
      ir_shift_r <= ir_shift_r;
      ir_r       <= ir_r;
      dsel_r     <= dsel_r;
    end
  end

  // Internal data registers: capture on the rise leaving CapDR, shift on each ShDR rise
  always_ff @(posedge wb_clk_i) begin
    if (rst_s) begin
      dr_r     <= 32'h0000_0000;
      bypass_r <= 1'b0;
    end else if (rise_s && (state_r == CAPDR)) begin
      dr_r     <= sel_idcode_s ? IDCODE_VALUE : dr_r;
      bypass_r <= 1'b0;
    end else if (rise_s && (state_r == SHDR)) begin
      dr_r     <= sel_idcode_s ? {tdi_s, dr_r[31:1]} : dr_r;
      bypass_r <= sel_bypass_s ? tdi_s : bypass_r;
    end else begin
      dr_r     <= dr_r;
      bypass_r <= bypass_r;
    end
  end

  // Debug-DR strobes; mutually exclusive because they key off different states
  always_ff @(posedge wb_clk_i) begin
    if (rst_s) begin
      capture_r <= 1'b0;
      shift_r   <= 1'b0;
      update_r  <= 1'b0;
      tdi_o_r   <= 1'b0;
    end else begin
      capture_r <= rise_s & (next_state_s == CAPDR) & dsel_r;
      shift_r   <= rise_s & (state_r == SHDR) & dsel_r;
      update_r  <= rise_s & (next_state_s == UPDDR) & dsel_r;
      tdi_o_r   <= (rise_s && (state_r == SHDR)) ? tdi_s : tdi_o_r;
    end
  end

  // tdo changes only on tck fall, driven from the selected register's LSB
  always_ff @(posedge wb_clk_i) begin
    if (rst_s) begin
      tdo_r <= 1'b0;
    end else if (fall_s) begin
      case (state_r)
        SHIR:    tdo_r <= ir_shift_r[0];
        SHDR:    tdo_r <= sel_idcode_s ? dr_r[0] : (dsel_r ? jtag.debug_tdo_i : bypass_r);
        default: tdo_r <= 1'b0;
      endcase
    end else begin
      tdo_r <= tdo_r;
    end
  end

  assign jtag.tdo_pad_o      = tdo_r;
  assign jtag.ir_o           = ir_r;
  assign jtag.debug_select_o = dsel_r;
  assign jtag.capture_dr_o   = capture_r;
  assign jtag.shift_dr_o     = shift_r;
  assign jtag.update_dr_o    = update_r;
  assign jtag.tdi_o          = tdi_o_r;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Directed, table-driven bench for jtag_tap_sampled: IR/DR scans from Run-Test/Idle plus
// hand-written sequences for UpdIR timing, tms-driven reset and mid-shift reset.
module tb_jtag_tap_sampled;

  typedef struct {
    string       name;
    bit          is_ir;
    int          nbits;
    logic [31:0] tdi;
    logic [31:0] dbg;
    logic [31:0] exp_tdo;
    logic [3:0]  exp_ir;
    logic        exp_dsel;
    int          exp_cap;
    int          exp_shf;
    int          exp_upd;
    bit          chk_tdi_o;
  } scan_t;

  logic        clk;
  logic        rst;
  int          total = 0;
  int          bad = 0;
  int          cap_cnt = 0, shf_cnt = 0, upd_cnt = 0, overlap_cnt = 0, wide_cnt = 0;
  logic        cap_q = 1'b0, shf_q = 1'b0, upd_q = 1'b0;
  logic [63:0] tdi_o_hist = 64'h0;
  scan_t       vec [9];

  jtag_tap_sampled_if #(.IR_WIDTH(4)) jif ();

  jtag_tap_sampled #(.IR_WIDTH(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .jtag     (jif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor: pulse counts, overlap, width, and tdi_o captured at each shift strobe
  always @(negedge clk) begin
    logic c, s, u;
    c = (jif.capture_dr_o === 1'b1);
    s = (jif.shift_dr_o === 1'b1);
    u = (jif.update_dr_o === 1'b1);
    if (c) cap_cnt++;
    if (s) begin
      shf_cnt++;
      tdi_o_hist = {jif.tdi_o, tdi_o_hist[63:1]};
    end
    if (u) upd_cnt++;
    if ((int'(c) + int'(s) + int'(u)) > 1) overlap_cnt++;
    if ((c & cap_q) | (s & shf_q) | (u & upd_q)) wide_cnt++;
    cap_q = c;
    shf_q = s;
    upd_q = u;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic scan_t mk(input string n, input bit ir, input int nb,
                               input logic [31:0] tdi, input logic [31:0] dbg,
                               input logic [31:0] etdo, input logic [3:0] eir,
                               input logic edsel, input int ec, input int es,
                               input int eu, input bit ctdo);
    scan_t s;
    s.name = n;     s.is_ir = ir;     s.nbits = nb;
    s.tdi = tdi;    s.dbg = dbg;      s.exp_tdo = etdo;
    s.exp_ir = eir; s.exp_dsel = edsel;
    s.exp_cap = ec; s.exp_shf = es;   s.exp_upd = eu;
    s.chk_tdi_o = ctdo;
    return s;
  endfunction

  // One full tck period; tdo sampled just before the rise, debug_tdo_i changes at the rise
  task automatic tck_cycle(input logic tms, input logic tdi, input logic dbg, output logic tdo_smp);
    jif.tms_pad_i = tms;
    jif.tdi_pad_i = tdi;
    repeat (4) @(posedge clk);
    #1;
    tdo_smp = jif.tdo_pad_o;
    jif.tck_pad_i   = 1'b1;
    jif.debug_tdo_i = dbg;
    repeat (4) @(posedge clk);
    #1;
    jif.tck_pad_i = 1'b0;
  endtask

  // Complete IR or DR scan starting and ending in Run-Test/Idle
  task automatic run_scan(input scan_t v);
    logic        t;
    logic [31:0] got, mask;
    logic [63:0] hist;
    int          c0, s0, u0, ir_bad;
    c0 = cap_cnt; s0 = shf_cnt; u0 = upd_cnt;
    got = 32'h0; ir_bad = 0;
    mask = (v.nbits >= 32) ? 32'hFFFF_FFFF : ((32'h1 << v.nbits) - 32'h1);
    tck_cycle(1'b1, 1'b0, 1'b0, t);
    if (v.is_ir) tck_cycle(1'b1, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, v.dbg[0], t);
    for (int i = 0; i < v.nbits; i++) begin
      tck_cycle((i == v.nbits - 1), v.tdi[i], (i + 1 < v.nbits) ? v.dbg[i+1] : 1'b0, t);
      got[i] = t;
      if (!v.is_ir && (jif.ir_o !== v.exp_ir)) ir_bad++;
    end
    tck_cycle(1'b1, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    check({v.name, ".tdo"}, got, v.exp_tdo & mask);
    check({v.name, ".ir"}, {28'h0, jif.ir_o}, {28'h0, v.exp_ir});
    check({v.name, ".dsel"}, {31'h0, jif.debug_select_o}, {31'h0, v.exp_dsel});
    check({v.name, ".cap"}, cap_cnt - c0, v.exp_cap);
    check({v.name, ".shf"}, shf_cnt - s0, v.exp_shf);
    check({v.name, ".upd"}, upd_cnt - u0, v.exp_upd);
    if (!v.is_ir) check({v.name, ".ir_steady"}, ir_bad, 0);
    if (v.chk_tdi_o) begin
      hist = tdi_o_hist >> (64 - v.nbits);
      check({v.name, ".tdi_o"}, hist[31:0], v.tdi & mask);
    end
  endtask

  initial begin
    logic        t;
    logic [31:0] got;
    int          u0;

    vec[0] = mk("idcode",      1'b0, 32, 32'h0,        32'h0,  32'h14951185, 4'h2, 1'b0, 0, 0, 0, 1'b0);
    vec[1] = mk("ir_debug",    1'b1, 4,  32'h8,        32'h0,  32'h1,        4'h8, 1'b1, 0, 0, 0, 1'b0);
    vec[2] = mk("debug_dr",    1'b0, 8,  32'hA5,       32'h3C, 32'h3C,       4'h8, 1'b1, 1, 8, 1, 1'b1);
    vec[3] = mk("ir_bypass",   1'b1, 4,  32'hF,        32'h0,  32'h1,        4'hF, 1'b0, 0, 0, 0, 1'b0);
    vec[4] = mk("bypass",      1'b0, 4,  32'hD,        32'h0,  32'hA,        4'hF, 1'b0, 0, 0, 0, 1'b0);
    vec[5] = mk("ir_unknown",  1'b1, 4,  32'h3,        32'h0,  32'h1,        4'h3, 1'b0, 0, 0, 0, 1'b0);
    vec[6] = mk("bypass_unk",  1'b0, 4,  32'h6,        32'h0,  32'hC,        4'h3, 1'b0, 0, 0, 0, 1'b0);
    vec[7] = mk("ir_idcode",   1'b1, 4,  32'h2,        32'h0,  32'h1,        4'h2, 1'b0, 0, 0, 0, 1'b0);
    vec[8] = mk("idcode_ones", 1'b0, 32, 32'hFFFFFFFF, 32'h0,  32'h14951185, 4'h2, 1'b0, 0, 0, 0, 1'b0);

    rst             = 1'b1;
    jif.tck_pad_i   = 1'b0;
    jif.tms_pad_i   = 1'b0;
    jif.tdi_pad_i   = 1'b0;
    jif.debug_tdo_i = 1'b0;
`ifdef JTAG_TAP_TRST_EN
    jif.trst_pad_i  = 1'b1;
`endif
    repeat (4) @(posedge clk);
    #1;
    check("rst.tdo",  {31'h0, jif.tdo_pad_o}, 32'h0);
    check("rst.ir",   {28'h0, jif.ir_o}, 32'h2);
    check("rst.dsel", {31'h0, jif.debug_select_o}, 32'h0);
    check("rst.strobes", {29'h0, jif.capture_dr_o, jif.shift_dr_o, jif.update_dr_o}, 32'h0);
    rst = 1'b0;

    // TLR -> RTI, then every table scan starts from RTI
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    for (int i = 0; i < 9; i++) run_scan(vec[i]);

    // IR <- 8, checking ir_o/debug_select_o land exactly one cycle after the UpdIR-entry rise
    tck_cycle(1'b1, 1'b0, 1'b0, t);
    tck_cycle(1'b1, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b0, 1'b0, t);
    tck_cycle(1'b1, 1'b1, 1'b0, t);
    jif.tms_pad_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    jif.tck_pad_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("updir.ir_before", {28'h0, jif.ir_o}, 32'h2);
    @(posedge clk);
    #1;
    check("updir.ir_after",   {28'h0, jif.ir_o}, 32'h8);
    check("updir.dsel_after", {31'h0, jif.debug_select_o}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    jif.tck_pad_i = 1'b0;
    tck_cycle(1'b0, 1'b0, 1'b0, t);

    // tms reset from Pause-DR: four rises are not enough, the fifth reaches TLR
    run_scan(vec[3]);
    u0 = upd_cnt;
    tck_cycle(1'b1, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    tck_cycle(1'b1, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    for (int i = 0; i < 4; i++) tck_cycle(1'b1, 1'b0, 1'b0, t);
    check("tmsrst.ir_after4", {28'h0, jif.ir_o}, 32'hF);
    tck_cycle(1'b1, 1'b0, 1'b0, t);
    check("tmsrst.ir", {28'h0, jif.ir_o}, 32'h2);
    check("tmsrst.dsel", {31'h0, jif.debug_select_o}, 32'h0);
    check("tmsrst.upd", upd_cnt - u0, 0);
    tck_cycle(1'b0, 1'b0, 1'b0, t);

    // Reset after 10 of 32 IDCODE shifts, then a clean full read
    u0 = upd_cnt;
    got = 32'h0;
    tck_cycle(1'b1, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    for (int i = 0; i < 10; i++) begin
      tck_cycle(1'b0, 1'b0, 1'b0, t);
      got[i] = t;
    end
    check("midrst.partial_tdo", got, 32'h185);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.tdo", {31'h0, jif.tdo_pad_o}, 32'h0);
    check("midrst.strobes", {29'h0, jif.capture_dr_o, jif.shift_dr_o, jif.update_dr_o}, 32'h0);
    check("midrst.ir", {28'h0, jif.ir_o}, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst.upd", upd_cnt - u0, 0);
    tck_cycle(1'b0, 1'b0, 1'b0, t);
    run_scan(vec[0]);

    check("strobe.overlap", overlap_cnt, 0);
    check("strobe.width", wide_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
